// File: rtl/fpu_mul_result_pack_if.sv
// Handshake and data bundle between the special-case select unit, the result
// packer and the downstream butterfly datapath.
interface fpu_mul_result_pack_if #(
    parameter int unsigned SIZE_EXP = 8,
    parameter int unsigned SIZE_MAN = 24
);
    logic                         i_valid;
    logic                         o_ready;
    logic                         i_sign;
    logic [SIZE_EXP+1:0]          i_exp_sum;
    logic [2*SIZE_MAN-1:0]        i_man_prod;
    logic [1:0]                   i_sel_exp;
    logic [1:0]                   i_sel_man;
    logic                         o_valid;
    logic                         i_ready;
    logic [SIZE_EXP+SIZE_MAN-1:0] o_result;
    logic                         o_overflow;
    logic                         o_underflow;

    modport slave (
        input  i_valid, i_sign, i_exp_sum, i_man_prod, i_sel_exp, i_sel_man, i_ready,
        output o_ready, o_valid, o_result, o_overflow, o_underflow
    );

    modport master (
        output i_valid, i_sign, i_exp_sum, i_man_prod, i_sel_exp, i_sel_man, i_ready,
        input  o_ready, o_valid, o_result, o_overflow, o_underflow
    );
endinterface

// File: rtl/fpu_mul_result_pack.sv
// Final FPU multiplier stage: normalise, round-to-nearest-even, range check and
// special-value muxing into a packed IEEE-754 result, over a 2-stage pipeline.
module fpu_mul_result_pack #(
    parameter int unsigned SIZE_EXP = 8,
    parameter int unsigned SIZE_MAN = 24,
    parameter int unsigned BIAS     = 127
) (
    input logic                  i_clk,
    input logic                  i_rst_n,
    fpu_mul_result_pack_if.slave bus
);
    localparam int unsigned W  = SIZE_MAN;
    localparam int unsigned FW = SIZE_MAN - 1;
    localparam int unsigned EW = SIZE_EXP + 2;
    localparam logic signed [EW-1:0] EXP_ALL_ONES = EW'(2 ** SIZE_EXP - 1);

    if (BIAS != 2 ** (SIZE_EXP - 1) - 1) begin : g_bias_check
        $error("BIAS does not match SIZE_EXP");
    end

    logic                 s1_valid_q, s1_valid_d;
    logic [FW-1:0]        s1_frac_q, s1_frac_d;
    logic                 s1_g_q, s1_g_d;
    logic                 s1_s_q, s1_s_d;
    logic signed [EW-1:0] s1_exp_q, s1_exp_d;
    logic                 s1_sign_q, s1_sign_d;
    logic [1:0]           s1_sel_exp_q, s1_sel_exp_d;
    logic [1:0]           s1_sel_man_q, s1_sel_man_d;

    logic                       valid_q, valid_d;
    logic [SIZE_EXP+FW:0]       result_q, result_d;
    logic                       ovf_q, ovf_d;
    logic                       unf_q, unf_d;

    logic                 s2_adv;
    logic                 round_up;
    logic [FW:0]          frac_sum;
    logic signed [EW-1:0] exp_rnd;
    logic [SIZE_EXP-1:0]  exp_out;
    logic [FW-1:0]        frac_out;
    logic                 sign_out;

    assign s2_adv      = ~valid_q | bus.i_ready;
    assign bus.o_ready = ~s1_valid_q | s2_adv;

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_frac_d    = s1_frac_q;
        s1_g_d       = s1_g_q;
        s1_s_d       = s1_s_q;
        s1_exp_d     = s1_exp_q;
        s1_sign_d    = s1_sign_q;
        s1_sel_exp_d = s1_sel_exp_q;
        s1_sel_man_d = s1_sel_man_q;
        if (bus.o_ready) begin
            s1_valid_d   = bus.i_valid;
            s1_sign_d    = bus.i_sign;
            s1_sel_exp_d = bus.i_sel_exp;
            s1_sel_man_d = bus.i_sel_man;
            if (bus.i_man_prod[2*W-1]) begin
                s1_frac_d = bus.i_man_prod[2*W-2:W];
                s1_g_d    = bus.i_man_prod[W-1];
                s1_s_d    = |bus.i_man_prod[W-2:0];
                s1_exp_d  = bus.i_exp_sum + EW'(1);
            end else begin
                s1_frac_d = bus.i_man_prod[2*W-3:W-1];
                s1_g_d    = bus.i_man_prod[W-2];
                s1_s_d    = |bus.i_man_prod[W-3:0];
                s1_exp_d  = bus.i_exp_sum;
            end
        end
    end

    always_comb begin
        round_up = s1_g_q & (s1_s_q | s1_frac_q[0]);
        frac_sum = {1'b0, s1_frac_q} + {{FW{1'b0}}, round_up};
        exp_rnd  = s1_exp_q + {{(EW-1){1'b0}}, frac_sum[FW]};
        sign_out = s1_sign_q;
        exp_out  = exp_rnd[SIZE_EXP-1:0];
        frac_out = frac_sum[FW-1:0];
        ovf_d    = 1'b0;
        unf_d    = 1'b0;
        // Range checks only apply to the computed exponent path
        unique case (s1_sel_exp_q)
            2'b00: begin
                if (!exp_rnd[EW-1] && exp_rnd >= EXP_ALL_ONES) begin
                    exp_out  = '1;
                    frac_out = '0;
                    ovf_d    = 1'b1;
                end else if (exp_rnd[EW-1] || exp_rnd == '0) begin
                    exp_out  = '0;
                    frac_out = '0;
                    unf_d    = 1'b1;
                end
            end
            2'b01:   exp_out = '0;
            2'b10:   exp_out = '1;
            default: begin
                exp_out  = '1;
                sign_out = 1'b0;
            end
        endcase
        unique case (s1_sel_man_q)
            2'b00:        ;
            2'b01, 2'b10: frac_out = '0;
            default:      frac_out = {1'b1, {(FW-1){1'b0}}};
        endcase
        valid_d  = valid_q;
        result_d = result_q;
        if (s2_adv) begin
            valid_d  = s1_valid_q;
            result_d = {sign_out, exp_out, frac_out};
        end else begin
            ovf_d = ovf_q;
            unf_d = unf_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_frac_q    <= '0;
            s1_g_q       <= 1'b0;
            s1_s_q       <= 1'b0;
            s1_exp_q     <= '0;
            s1_sign_q    <= 1'b0;
            s1_sel_exp_q <= 2'b00;
            s1_sel_man_q <= 2'b00;
            valid_q      <= 1'b0;
            result_q     <= '0;
            ovf_q        <= 1'b0;
            unf_q        <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_frac_q    <= s1_frac_d;
            s1_g_q       <= s1_g_d;
            s1_s_q       <= s1_s_d;
            s1_exp_q     <= s1_exp_d;
            s1_sign_q    <= s1_sign_d;
            s1_sel_exp_q <= s1_sel_exp_d;
            s1_sel_man_q <= s1_sel_man_d;
            valid_q      <= valid_d;
            result_q     <= result_d;
            ovf_q        <= ovf_d;
            unf_q        <= unf_d;
        end
    end

    assign bus.o_valid     = valid_q;
    assign bus.o_result    = result_q;
    assign bus.o_overflow  = ovf_q;
    assign bus.o_underflow = unf_q;
endmodule
